// File: rtl/aibio_pi_ctrl_pkg.sv
// Shared widths, FSM/direction enums and decode helpers for the PI code controller.
package aibio_pi_ctrl_pkg;

    localparam int POS_W  = 6;
    localparam int SEG_W  = 3;
    localparam int FINE_W = 3;
    localparam int SEL_W  = 1 << SEG_W;

    localparam logic [POS_W-1:0] POS_HALF = POS_W'(1) << (POS_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    function automatic logic [SEL_W-1:0] seg2onehot(input logic [SEG_W-1:0] seg);
        return SEL_W'(1) << seg;
    endfunction

    function automatic logic [SEL_W-1:0] fine2therm(input logic [FINE_W-1:0] fine);
        return (SEL_W'(1) << fine) - SEL_W'(1);
    endfunction

    // Shortest path around the 64-position ring; an exact half-turn goes up.
    function automatic dir_e step_dir(input logic [POS_W-1:0] pos,
                                      input logic [POS_W-1:0] tgt);
        logic [POS_W-1:0] d;
        d = tgt - pos;
        if (d == '0)
            return DIR_HOLD;
        else if (d <= POS_HALF)
            return DIR_UP;
        else
            return DIR_DOWN;
    endfunction

endpackage

// File: rtl/aibio_pi_pos_stepper.sv
// One PI path: position register that walks one LSB toward its target per step,
// with registered mixer one-hot and thermometer decode of the next position.
module aibio_pi_pos_stepper
    import aibio_pi_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstb,
    input  logic             i_step,
    input  logic [POS_W-1:0] i_tgt,
    output logic [POS_W-1:0] o_pos,
    output logic             o_at_tgt,
    output logic [SEL_W-1:0] o_mixer,
    output logic [SEL_W-1:0] o_code
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [SEL_W-1:0] mixer_q, mixer_d;
    logic [SEL_W-1:0] code_q, code_d;

    always_comb begin
        pos_d = pos_q;
        if (i_step) begin
            case (step_dir(pos_q, i_tgt))
                DIR_UP:   pos_d = pos_q + 1'b1;
                DIR_DOWN: pos_d = pos_q - 1'b1;
                default:  pos_d = pos_q;
            endcase
        end
        // Decode from pos_d so the mixer/code flops change on the same edge as pos.
        mixer_d = seg2onehot(pos_d[POS_W-1 -: SEG_W]);
        code_d  = fine2therm(pos_d[FINE_W-1:0]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            pos_q   <= '0;
            mixer_q <= SEL_W'(1);
            code_q  <= '0;
        end else begin
            pos_q   <= pos_d;
            mixer_q <= mixer_d;
            code_q  <= code_d;
        end
    end

    assign o_pos    = pos_q;
    assign o_at_tgt = (pos_q == i_tgt);
    assign o_mixer  = mixer_q;
    assign o_code   = code_q;

endmodule

// File: rtl/aibio_pi_code_ctrl.sv
// PI code controller: load FSM and step-rate divider driving the even/odd position steppers.
module aibio_pi_code_ctrl #(
    parameter int POS_W = 6,
    parameter int DIV_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rstb,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [POS_W-1:0] i_evn_target,
    input  logic [POS_W-1:0] i_odd_target,
    input  logic [DIV_W-1:0] i_step_div,
    output logic             o_pien,
    output logic [7:0]       o_pimixer_evn,
    output logic [7:0]       o_pimixer_odd,
    output logic [7:0]       o_pievn_code,
    output logic [7:0]       o_piodd_code,
    output logic             o_busy,
    output logic             o_done
);
    import aibio_pi_ctrl_pkg::*;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [POS_W-1:0] evn_tgt_q, evn_tgt_d, odd_tgt_q, odd_tgt_d;
    logic             step_q, step_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pien_q, pien_d;

    logic [POS_W-1:0] evn_pos, odd_pos;
    logic             evn_at, odd_at, at_both;
    logic             start, start_match, step;

    assign at_both     = evn_at && odd_at;
    assign start       = i_load || pend_q;
    assign start_match = i_load ? (i_evn_target == evn_pos && i_odd_target == odd_pos) : at_both;

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            state_q   <= IDLE;
            div_q     <= '0;
            evn_tgt_q <= '0;
            odd_tgt_q <= '0;
            step_q    <= 1'b0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pien_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            evn_tgt_q <= evn_tgt_d;
            odd_tgt_q <= odd_tgt_d;
            step_q    <= step_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pien_q    <= pien_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = start_match ? DONE : WAIT;
                // A load in the same cycle as arrival must be re-evaluated first.
                WAIT:    if (!i_load && at_both) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        evn_tgt_d = (i_en && i_load) ? i_evn_target : evn_tgt_q;
        odd_tgt_d = (i_en && i_load) ? i_odd_target : odd_tgt_q;
        pend_d    = i_en && i_load && (state_q == DONE);
        div_d     = '0;
        if (i_en && state_q == WAIT)
            div_d = (div_q == i_step_div) ? '0 : div_q + 1'b1;
        // Strobe is registered, so the first step lands i_step_div+1 cycles after busy.
        step_d = i_en && (state_q == WAIT) && (div_q == i_step_div);
        busy_d = (state_q == WAIT) && (state_d == WAIT);
        done_d = (state_d == DONE);
        pien_d = i_en;
    end

    assign step = step_q && i_en && (state_q == WAIT);

    aibio_pi_pos_stepper u_evn (
        .i_clk    (i_clk),
        .i_rstb   (i_rstb),
        .i_step   (step),
        .i_tgt    (evn_tgt_q),
        .o_pos    (evn_pos),
        .o_at_tgt (evn_at),
        .o_mixer  (o_pimixer_evn),
        .o_code   (o_pievn_code)
    );

    aibio_pi_pos_stepper u_odd (
        .i_clk    (i_clk),
        .i_rstb   (i_rstb),
        .i_step   (step),
        .i_tgt    (odd_tgt_q),
        .o_pos    (odd_pos),
        .o_at_tgt (odd_at),
        .o_mixer  (o_pimixer_odd),
        .o_code   (o_piodd_code)
    );

    assign o_pien = pien_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_aibio_pi_code_ctrl.sv
// Bench for aibio_pi_code_ctrl: table of moves checked cycle-by-cycle against a
// queue of expected positions, plus retarget, enable-drop and reset corner cases.
module tb_aibio_pi_code_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rstb, i_en, i_load;
    logic [5:0] i_evn_target, i_odd_target;
    logic [3:0] i_step_div;
    logic       o_pien, o_busy, o_done;
    logic [7:0] o_pimixer_evn, o_pimixer_odd, o_pievn_code, o_piodd_code;

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0]  m_evn = '0;
    logic [5:0]  m_odd = '0;
    logic [11:0] sb_q[$];

    typedef struct {
        logic [5:0] et;
        logic [5:0] ot;
        logic [3:0] dv;
        logic [7:0] fmix;
        logic [7:0] fcode;
    } vec_t;

    vec_t tbl[8];

    always #5 i_clk = ~i_clk;

    aibio_pi_code_ctrl #(.POS_W(6), .DIV_W(4)) dut (
        .i_clk         (i_clk),
        .i_rstb        (i_rstb),
        .i_en          (i_en),
        .i_load        (i_load),
        .i_evn_target  (i_evn_target),
        .i_odd_target  (i_odd_target),
        .i_step_div    (i_step_div),
        .o_pien        (o_pien),
        .o_pimixer_evn (o_pimixer_evn),
        .o_pimixer_odd (o_pimixer_odd),
        .o_pievn_code  (o_pievn_code),
        .o_piodd_code  (o_piodd_code),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    function automatic logic [15:0] dec(input logic [5:0] p);
        logic [7:0] mix, code;
        mix  = 8'h01 << p[5:3];
        code = (8'h01 << p[2:0]) - 8'h01;
        return {mix, code};
    endfunction

    function automatic logic [31:0] expv(input logic [5:0] e, input logic [5:0] o);
        return {dec(e), dec(o)};
    endfunction

    function automatic logic [5:0] mv(input logic [5:0] p, input logic [5:0] t);
        logic [5:0] d;
        d = t - p;
        if (d == 6'd0)  return p;
        if (d <= 6'd32) return p + 6'd1;
        return p - 6'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dutv();
        return {o_pimixer_evn, o_pievn_code, o_pimixer_odd, o_piodd_code};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Load new targets and follow the move; expected positions are queued up front.
    task automatic do_move(input logic [5:0] et, input logic [5:0] ot, input logic [3:0] dv,
                           input logic [7:0] fmix, input logic [7:0] fcode);
        logic [5:0]  pe, po;
        logic [11:0] cur;
        int          k, last;
        pe = m_evn;
        po = m_odd;
        k  = 0;
        while ((pe != et || po != ot) && k < 64) begin
            pe = mv(pe, et);
            po = mv(po, ot);
            sb_q.push_back({pe, po});
            k++;
        end
        i_evn_target = et;
        i_odd_target = ot;
        i_step_div   = dv;
        i_load       = 1'b1;
        tick();
        i_load = 1'b0;
        cur = {m_evn, m_odd};
        if (k == 0) begin
            chk("nomove_status", {30'd0, o_busy, o_done}, 32'd1);
            chk("nomove_pos", dutv(), expv(cur[11:6], cur[5:0]));
        end else begin
            last = 1 + k * (int'(dv) + 1);
            for (int c = 1; c <= last; c++) begin
                tick();
                if (c > 1 && ((c - 1) % (int'(dv) + 1)) == 0 && sb_q.size() > 0)
                    cur = sb_q.pop_front();
                chk("move_pos", dutv(), expv(cur[11:6], cur[5:0]));
                chk("move_status", {30'd0, o_busy, o_done}, 32'd2);
            end
            tick();
            chk("done_status", {30'd0, o_busy, o_done}, 32'd1);
            chk("final_evn", {16'd0, o_pimixer_evn, o_pievn_code}, {16'd0, fmix, fcode});
        end
        tick();
        chk("done_clear", {30'd0, o_busy, o_done}, 32'd0);
        sb_q.delete();
        m_evn = et;
        m_odd = ot;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        logic [5:0] ep;

        tbl[0] = '{et: 6'd5,  ot: 6'd0,  dv: 4'd0, fmix: 8'h01, fcode: 8'h1F};
        tbl[1] = '{et: 6'd2,  ot: 6'd0,  dv: 4'd0, fmix: 8'h01, fcode: 8'h03};
        tbl[2] = '{et: 6'd60, ot: 6'd0,  dv: 4'd0, fmix: 8'h80, fcode: 8'h0F};
        tbl[3] = '{et: 6'd0,  ot: 6'd0,  dv: 4'd1, fmix: 8'h01, fcode: 8'h00};
        tbl[4] = '{et: 6'd32, ot: 6'd0,  dv: 4'd0, fmix: 8'h10, fcode: 8'h00};
        tbl[5] = '{et: 6'd40, ot: 6'd63, dv: 4'd2, fmix: 8'h20, fcode: 8'h00};
        tbl[6] = '{et: 6'd40, ot: 6'd63, dv: 4'd0, fmix: 8'h20, fcode: 8'h00};
        tbl[7] = '{et: 6'd0,  ot: 6'd0,  dv: 4'd0, fmix: 8'h01, fcode: 8'h00};

        i_rstb = 1'b0; i_en = 1'b1; i_load = 1'b0;
        i_evn_target = '0; i_odd_target = '0; i_step_div = '0;

        // Reset values, and enable visible one cycle after release.
        repeat (2) tick();
        chk("rst_pos", dutv(), 32'h01000100);
        chk("rst_status", {29'd0, o_pien, o_busy, o_done}, 32'd0);
        i_rstb = 1'b1;
        tick();
        chk("rst_pien", {31'd0, o_pien}, 32'd1);
        chk("rst_hold", dutv(), 32'h01000100);
        tick();

        for (int i = 0; i < 8; i++)
            do_move(tbl[i].et, tbl[i].ot, tbl[i].dv, tbl[i].fmix, tbl[i].fcode);

        // div=3: steps 4 cycles apart; retarget at pos 4 reverses without clearing the divider.
        i_evn_target = 6'd10; i_odd_target = 6'd0; i_step_div = 4'd3; i_load = 1'b1;
        tick();
        i_load = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 29; c++) begin
            tick();
            if (c < 5)       ep = 6'd0;
            else if (c <= 20) ep = 6'((c - 1) / 4);
            else if (c <= 24) ep = 6'd3;
            else              ep = 6'd2;
            chk("retgt_pos", dutv(), expv(ep, 6'd0));
            chk("retgt_busy", {31'd0, o_busy}, {31'd0, c <= 25});
            chk("retgt_done", {31'd0, o_done}, {31'd0, c == 26});
            if (o_done) ndone++;
            if (c == 17) begin i_evn_target = 6'd2; i_load = 1'b1; end
            if (c == 18) i_load = 1'b0;
        end
        chk("retgt_ndone", ndone, 32'd1);
        m_evn = 6'd2;

        // Drop enable at pos 3: hold, no busy, no done; resume from 3 afterwards.
        i_evn_target = 6'd10; i_step_div = 4'd0; i_load = 1'b1;
        tick();
        i_load = 1'b0;
        tick();
        tick();
        chk("endrop_pre", dutv(), expv(6'd3, 6'd0));
        i_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("endrop_status", {29'd0, o_pien, o_busy, o_done}, 32'd0);
            chk("endrop_pos", dutv(), expv(6'd3, 6'd0));
        end
        i_en = 1'b1;
        tick();
        chk("reen_pien", {31'd0, o_pien}, 32'd1);
        chk("reen_idle", {30'd0, o_busy, o_done}, 32'd0);
        m_evn = 6'd3;
        do_move(6'd5, 6'd0, 4'd0, 8'h01, 8'h1F);

        // Reset mid-move: everything back to reset values, no done afterwards.
        i_evn_target = 6'd20; i_load = 1'b1;
        tick();
        i_load = 1'b0;
        repeat (3) tick();
        chk("midrst_pre", dutv(), expv(6'd7, 6'd0));
        i_rstb = 1'b0;
        tick();
        chk("midrst_pos", dutv(), 32'h01000100);
        chk("midrst_status", {29'd0, o_pien, o_busy, o_done}, 32'd0);
        i_rstb = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (o_done) ndone++;
            chk("midrst_hold", dutv(), 32'h01000100);
        end
        chk("midrst_ndone", ndone, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aibio_pi_code_ctrl.md
# aibio_pi_code_ctrl

Digital phase-interpolator code controller for the RX DLL. It sits directly upstream of the even/odd PI mixer pair. It converts two 6-bit target phase positions into the mixer-select one-hot vectors, the thermometer interpolation codes and the PI enable that the mixer stage consumes. Positions move toward their targets one LSB per step, along the shortest path with wrap-around, at a programmable step rate, so the analog mixers never see a multi-LSB phase jump.

## Interface
Parameters:
- POS_W, 6, phase position width; upper 3 bits are the segment, lower 3 bits are the fine position.
- DIV_W, 4, width of the step-interval divider.

Ports:
- i_clk  input  1  controller clock; one clock domain.
- i_rstb  input  1  reset, synchronous, active-low.
- i_en  input  1  controller enable; low forces idle and drives o_pien low.
- i_load  input  1  one-cycle pulse that captures new targets.
- i_evn_target  input  POS_W  target position, even path.
- i_odd_target  input  POS_W  target position, odd path.
- i_step_div  input  DIV_W  step interval is i_step_div+1 cycles.
- o_pien  output  1  PI enable to the mixers.
- o_pimixer_evn / o_pimixer_odd  output  8  one-hot segment select.
- o_pievn_code / o_piodd_code  output  8  thermometer fine code.
- o_busy  output  1  high while stepping.
- o_done  output  1  one-cycle pulse when both paths reach their targets.

## Operation
- Each path holds a position register pos in the range 0..63.
- Output decode:
  - mixer = 1 << pos[5:3].
  - code = (1 << pos[2:0]) - 1, i.e. pos[2:0] ones at the LSBs (0 gives 8'h00, 7 gives 8'h7F).
- Direction: d = (target - pos) mod 64.
  - d = 0: hold.
  - 1 ≤ d ≤ 32: increment (a tie at 32 goes up).
  - d > 32: decrement.
  - Increment and decrement wrap modulo 64 (63+1 = 0, 0-1 = 63).
- Both paths step on the same step strobe, independently. A path already at its target holds.
- FSM states:
  - IDLE: o_busy = 0. When i_load is seen with i_en = 1, capture both targets and clear the divider. Go to WAIT if either d ≠ 0, otherwise go to DONE.
  - WAIT: o_busy = 1. The divider increments every cycle. When divider == i_step_div, issue a step strobe and clear the divider. Go to DONE in the cycle after the step that makes both positions equal their targets.
  - DONE: o_done = 1 for one cycle, o_busy = 0. Next state is IDLE.
- i_load in WAIT: replaces the targets immediately; the divider is not cleared. If the new targets equal the current positions, go to DONE on the next cycle.
- i_load in DONE: treated as an IDLE load on the following cycle. It is registered, not lost.
- i_en = 0 in any state:
  - go to IDLE next cycle; positions and targets hold; o_pien = 0.
  - no o_done is issued; pending loads are discarded.
- i_en = 1: o_pien = 1 one cycle after i_en is sampled high.
- i_step_div is sampled live. Changing it mid-move takes effect at the next compare.

## Timing
- All outputs are flops. The mixer and code outputs are loaded from the decode of the next position, so they change on the same edge as pos.
- Reset values:
  - pos = 0 for both paths, targets = 0.
  - o_pimixer_* = 8'h01, o_pi*_code = 8'h00.
  - o_pien = 0, o_busy = 0, o_done = 0, FSM in IDLE.
- Load latency: i_load is sampled at edge N; o_busy = 1 after edge N+1. The first step lands at edge N+1+(i_step_div+1).
- Move duration: a move of k LSBs with a constant divider takes k·(i_step_div+1) cycles from busy rising to the last step. o_done asserts the cycle after the last step.
- Reset mid-move: all state returns to reset values on the next edge. No o_done is issued.

## Structure
- Package aibio_pi_ctrl_pkg holds:
  - POS_W, SEG_W = 3, FINE_W = 3.
  - the FSM state enum (IDLE, WAIT, DONE).
  - functions seg2onehot, fine2therm and step_dir (returns hold/up/down from pos and target).
- Sub-module aibio_pi_pos_stepper: one position register, direction logic and output decode. It is instantiated twice (even and odd). The FSM and divider live in the top.

## Test plan
- Reset check: drive i_rstb low for 2 cycles with i_en = 1 → mixer outputs = 8'h01, codes = 8'h00, o_busy = 0, o_done = 0. o_pien = 1 one cycle after release.
- Up move: load evn = 5, odd = 0, div = 0.
  - o_pievn_code steps 01, 03, 07, 0F, 1F on consecutive cycles.
  - o_pimixer_odd stays 8'h01.
  - o_done pulses one cycle after the fifth step.
- Wrap-down: from evn = 2, load 60 → sequence 1, 0, 63 (mixer 8'h80, code 8'h7F), 62, 61, 60. Six steps, decrementing.
- Tie case: from 0, load 32 → increments through 8 (mixer 8'h02, code 8'h00) and reaches 32 (mixer 8'h10) after 32 steps.
- Divider and retarget: div = 3, load evn = 10.
  - steps are spaced 4 cycles apart.
  - at pos = 4, load evn = 2 → reverses direction without clearing the divider and ends at 2 with one o_done.
- Enable drop: drop i_en mid-move at pos = 3 →
  - o_pien = 0 next cycle, position holds at 3, o_busy = 0, no o_done.
  - a new load after re-enable resumes from 3.
